// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer.
// Optional perf counters enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage #(
    parameter int DATA_W     = 64,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_n;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_n;
    logic              skid_valid;
    logic              accept;
    logic              deliver;
    logic              killed;

    // All status flags decode straight from the state flops.
    assign out_valid  = (state == HALF) || (state == FULL);
    assign skid_valid = (state == FULL);
    assign in_ready   = !skid_valid;
    assign out_data   = main_data;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;
    assign killed  = flush && (skid_valid || (out_valid && !out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            main_data <= main_n;
            skid_data <= skid_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_data;
        skid_n  = skid_data;
        if (flush) begin
            state_n = EMPTY;
            if (CLEAR_DATA != 0) begin
                main_n = '0;
                skid_n = '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = HALF;
                        main_n  = in_data;
                    end
                end
                HALF: begin
                    if (accept && deliver) begin
                        main_n = in_data;
                    end else if (accept) begin
                        state_n = FULL;
                        skid_n  = in_data;
                    end else if (deliver) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_n = HALF;
                        main_n  = skid_data;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (killed) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall = stall_cnt;
    assign perf_flush = flush_cnt;
`else
    logic unused_perf;

    assign unused_perf = killed;
    assign perf_stall  = 32'd0;
    assign perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed table-driven bench for pipe_skid_stage.
// Perf section follows PIPE_SKID_PERF_EN like the design.
module tb_pipe_skid_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [31:0]  perf_stall;
    logic [31:0]  perf_flush;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         f;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    pipe_skid_stage #(.DATA_W(W), .CLEAR_DATA(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .perf_stall (perf_stall),
        .perf_flush (perf_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic ev, input logic er,
                       input logic [W-1:0] ed);
        vec_t v;
        v.f = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic step(input logic f, input logic iv, input logic [W-1:0] id,
                        input logic ordy);
        @(negedge clk);
        flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stream 1..8 at full rate
        for (int k = 1; k <= 8; k++) add(0, 1, W'(k), 1, 1, 1, W'(k));
        add(0, 0, 0, 1, 0, 1, 16'd8);
        // back-pressure with skid fill and drain
        add(0, 1, 16'd5, 1, 1, 1, 16'd5);
        add(0, 1, 16'd6, 0, 1, 0, 16'd5);
        add(0, 1, 16'd7, 0, 1, 0, 16'd5);
        add(0, 1, 16'd7, 1, 1, 1, 16'd6);
        add(0, 1, 16'd7, 1, 1, 1, 16'd7);
        add(0, 0, 0, 1, 0, 1, 16'd7);
        // flush in FULL with a beat offered
        add(0, 1, 16'd10, 0, 1, 1, 16'd10);
        add(0, 1, 16'd11, 0, 1, 0, 16'd10);
        add(1, 1, 16'd9, 0, 0, 1, 16'd0);
        add(0, 0, 0, 1, 0, 1, 16'd0);
        // flush with same-cycle delivery
        add(0, 1, 16'd12, 1, 1, 1, 16'd12);
        add(1, 0, 0, 1, 0, 1, 16'd0);
        add(0, 1, 16'd13, 1, 1, 1, 16'd13);
        add(0, 0, 0, 1, 0, 1, 16'd13);

        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].f, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].er));
            chk($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].ed));
        end

        // async reset while FULL, away from any clock edge
        step(0, 1, 16'd20, 0);
        step(0, 1, 16'd21, 0);
        chk("pre-rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'd0);
        chk("async in_ready", 64'(in_ready), 64'd1);
        chk("async out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 1);
        chk("post-rst out_valid", 64'(out_valid), 64'd0);

`ifdef PIPE_SKID_PERF_EN
        chk("perf_stall rst", 64'(perf_stall), 64'd0);
        step(0, 1, 16'd30, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        chk("perf_stall 10", 64'(perf_stall), 64'd10);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        step(0, 0, 0, 0);
        chk("perf_stall wrap", 64'(perf_stall), 64'd0);
        step(1, 0, 0, 1);
        chk("perf_flush deliv", 64'(perf_flush), 64'd0);
        step(0, 1, 16'd31, 0);
        step(1, 0, 0, 0);
        chk("perf_flush kill", 64'(perf_flush), 64'd1);
        step(1, 0, 0, 0);
        chk("perf_flush empty", 64'(perf_flush), 64'd1);
`else
        step(0, 1, 16'd30, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("perf_stall tied", 64'(perf_stall), 64'd0);
        chk("perf_flush tied", 64'(perf_flush), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
